// File: rtl/mul_req_arbiter_ctrl.sv
// Round-robin share of one registered multiply unit between two requesters; accept-to-resp latency LAT+1.
// The result is held in RESP until the owner takes it, and nothing new is accepted until then.
module mul_req_arbiter_ctrl #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int LAT   = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [XLEN-1:0]  req0_a_i,
   input  logic [XLEN-1:0]  req0_b_i,
   input  logic [1:0]       req0_funct_i,
   input  logic [TAG_W-1:0] req0_tag_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [XLEN-1:0]  req1_a_i,
   input  logic [XLEN-1:0]  req1_b_i,
   input  logic [1:0]       req1_funct_i,
   input  logic [TAG_W-1:0] req1_tag_i,
   output logic             resp0_valid_o,
   input  logic             resp0_ready_i,
   output logic             resp1_valid_o,
   input  logic             resp1_ready_i,
   output logic [XLEN-1:0]  resp_data_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic [XLEN-1:0]  mul_multiplier_o,
   output logic [XLEN-1:0]  mul_multiplicand_o,
   output logic [1:0]       mul_funct_o,
   output logic             mul_valid_in_o,
   input  logic [XLEN-1:0]  mul_data_out_i,
   output logic             busy_o
);

   localparam int CW = $clog2(LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [1:0]       funct;
      logic [TAG_W-1:0] tag;
   } op_t;

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic            owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   op_t             op_q, op_d;

   logic            ptr_vld;
   logic            grant_id;
   logic            accept;
   logic            owner_rdy;

   // The pointer requester wins if valid; otherwise the other one (only used when some valid is high).
   assign ptr_vld  = ptr_q ? req1_valid_i : req0_valid_i;
   assign grant_id = ptr_vld ? ptr_q : ~ptr_q;
   assign accept   = (state_q == IDLE) & ~flush_i & ~rst_i & (req0_valid_i | req1_valid_i);

   assign req0_ready_o = accept & ~grant_id & req0_valid_i;
   assign req1_ready_o = accept &  grant_id & req1_valid_i;

   assign owner_rdy = owner_q ? resp1_ready_i : resp0_ready_i;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               cnt_d   = CNT_INIT;
               owner_d = grant_id;
               if (grant_id) begin
                  op_d = '{a: req1_a_i, b: req1_b_i, funct: req1_funct_i, tag: req1_tag_i};
               end else begin
                  op_d = '{a: req0_a_i, b: req0_b_i, funct: req0_funct_i, tag: req0_tag_i};
               end
            end
         end
         EXEC: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            // A flush discards the result even if the owner is taking it this cycle.
            if (flush_i) begin
               state_d = IDLE;
            end else if (owner_rdy) begin
               state_d = IDLE;
               ptr_d   = ~owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign resp0_valid_o      = (state_q == RESP) & ~owner_q;
   assign resp1_valid_o      = (state_q == RESP) &  owner_q;
   assign resp_data_o        = (state_q == RESP) ? mul_data_out_i : '0;
   assign resp_tag_o         = (state_q == RESP) ? op_q.tag : '0;
   assign mul_multiplier_o   = op_q.a;
   assign mul_multiplicand_o = op_q.b;
   assign mul_funct_o        = op_q.funct;
   assign mul_valid_in_o     = (state_q == EXEC);
   assign busy_o             = (state_q != IDLE);

endmodule
